// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store unit between the CPU datapath and a
// 32-bit word-addressed data memory with variable latency.
// Latency: request accepted at cycle 0, mem_req from cycle 1, resp_valid one
//   cycle after the last mem_ack (cycle 1 for errors caught at accept).
// Backpressure: req_ready only in IDLE; mem_* held stable until mem_ack, with
//   an optional per-request TIMEOUT (0 disables it).
// Ports: clk/rst (sync, active-high); req_* CPU request (valid/ready);
//   resp_* one-cycle completion pulse with data/error; mem_* memory request
//   side (big-endian lanes: be[3] / bits [31:24] = byte offset 0).
// Build option: define MISALIGN_SPLIT_EN to allow any alignment, splitting
//   word-crossing accesses into two memory transactions; without it,
//   misaligned halfwords/words complete with resp_err and no memory access.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_zext,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_legal;
  logic [2:0]        nbytes;
  logic              crosses;
  logic              second;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0][7:0]   st_left;
  logic [3:0][7:0]   rd_lanes;
  logic [3:0][7:0]   lane_wdata;
  logic [3:0][7:0]   buf_upd;
  logic [3:0]        lane_be;
  logic [2:0]        pos;
  logic [1:0]        lane;
  logic [31:0]       ld_val;

  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    req_legal = (req_size != 2'b11);
`else
    case (req_size)
      2'b00:   req_legal = (req_addr[1:0] == 2'b00);
      2'b01:   req_legal = ~req_addr[0];
      2'b10:   req_legal = 1'b1;
      default: req_legal = 1'b0;
    endcase
`endif
  end

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd4;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd1;
    endcase
  end

  // offset + size beyond 4 bytes spills into the next word (max 3 + 4 = 7)
  assign crosses   = ({1'b0, addr_q[1:0]} + nbytes) > 3'd4;
  assign second    = (state_q == ACC2);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign rd_lanes  = mem_rdata;

  // Store value left-justified so that index 3 holds the lowest-address byte
  always_comb begin
    case (size_q)
      2'b00:   st_left = wdata_q;
      2'b01:   st_left = {wdata_q[15:0], 16'h0000};
      default: st_left = {wdata_q[7:0], 24'h000000};
    endcase
  end

  // Access byte j sits at offset+j: bit 2 selects the word (first/second),
  // bits [1:0] the lane. Only bytes belonging to the current word are mapped.
  always_comb begin
    lane_be    = '0;
    lane_wdata = '0;
    buf_upd    = buf_q;
    pos        = '0;
    lane       = '0;
    for (int j = 0; j < 4; j++) begin
      pos  = {1'b0, addr_q[1:0]} + 3'(j);
      lane = pos[1:0];
      if ((3'(j) < nbytes) && (pos[2] == second)) begin
        lane_be[2'd3 - lane]    = 1'b1;
        lane_wdata[2'd3 - lane] = st_left[2'(3 - j)];
        buf_upd[2'(3 - j)]      = rd_lanes[2'd3 - lane];
      end
    end
  end

  // buf_q holds collected bytes left-justified, lowest address in [31:24]
  always_comb begin
    case (size_q)
      2'b00:   ld_val = buf_q;
      2'b01:   ld_val = {{16{~zext_q & buf_q[31]}}, buf_q[31:16]};
      default: ld_val = {{24{~zext_q & buf_q[31]}}, buf_q[31:24]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    size_d     = size_q;
    zext_d     = zext_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          zext_d  = req_zext;
          wdata_d = req_wdata;
          buf_d   = '0;
          cnt_d   = '0;
          err_d   = ~req_legal;
          state_d = req_legal ? ACC1 : RESP;
        end
      end
      ACC1, ACC2: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = second ? (word_addr + ADDR_W'(4)) : word_addr;
        mem_be    = write_q ? lane_be : 4'hF;
        mem_wdata = lane_wdata;
        // ack is checked before expiry so a same-cycle ack completes normally
        if (mem_ack) begin
          if (!write_q) buf_d = buf_upd;
          cnt_d   = '0;
          state_d = (!second && crosses) ? ACC2 : RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || write_q) ? 32'h0 : ld_val;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      zext_q  <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: randomized loads/stores against a byte-level
// reference model, plus directed reset, timeout and mid-access reset cases.
// The bench acts as the memory, acking after a chosen number of wait cycles.
module tb_mem_access_unit;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_zext = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_zext(req_zext),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int nchecks = 0;
  int nerrors = 0;

  // observations of one access
  int          obs_ntx, obs_resp_cyc, obs_first_req_cyc, obs_req_cycles;
  logic [31:0] obs_addr [2];
  logic [31:0] obs_wdata [2];
  logic [3:0]  obs_be [2];
  logic        obs_we [2];
  logic [31:0] obs_rdata;
  logic        obs_err, obs_ready_acc, obs_ready_after, obs_unstable;

  // model expectations
  int          exp_ntx;
  logic        exp_err;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_wdata [2];
  logic [3:0]  exp_be [2];
  logic [31:0] exp_rdata;

  // Byte-level model: byte b of the access lives at address addr+b, in word
  // (offset+b)/4 of the access and big-endian lane (addr+b)%4.
  task automatic model(input logic w, input logic [31:0] addr, input logic [1:0] size,
                       input logic zext, input logic [31:0] wdata,
                       input logic [31:0] rdw0, input logic [31:0] rdw1);
    int n, off, t, k;
    logic [31:0] ba, val, rdw [2];
    rdw[0] = rdw0; rdw[1] = rdw1;
    off = int'(addr[1:0]);
    n = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
`ifdef MISALIGN_SPLIT_EN
    exp_err = (size == 2'b11);
`else
    exp_err = (size == 2'b11) || (off % n != 0);
`endif
    exp_ntx = exp_err ? 0 : ((off + n > 4) ? 2 : 1);
    exp_addr[0] = addr & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_be[0] = 4'h0; exp_be[1] = 4'h0;
    exp_wdata[0] = 32'h0; exp_wdata[1] = 32'h0;
    val = 32'h0;
    for (int b = 0; b < n; b++) begin
      ba = addr + 32'(b);
      t  = (off + b) / 4;
      k  = int'(ba[1:0]);
      val = (val << 8) | ((rdw[t] >> (8 * (3 - k))) & 32'hFF);
      exp_be[t][3 - k] = 1'b1;
      exp_wdata[t] = exp_wdata[t] | (((wdata >> (8 * (n - 1 - b))) & 32'hFF) << (8 * (3 - k)));
    end
    if (!w) begin exp_be[0] = 4'hF; exp_be[1] = 4'hF; end
    if (n < 4 && !zext && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
    exp_rdata = (exp_err || w) ? 32'h0 : val;
  endtask

  // Drive one request and behave as the memory; records what the DUT did.
  task automatic run_access(input logic w, input logic [31:0] addr, input logic [1:0] size,
                            input logic zext, input logic [31:0] wdata, input int waits,
                            input bit no_ack, input logic [31:0] rdw0, input logic [31:0] rdw1);
    int cyc, wcnt;
    bit done, in_tx;
    obs_ntx = 0; obs_resp_cyc = -1; obs_first_req_cyc = -1; obs_req_cycles = 0;
    obs_rdata = 'x; obs_err = 'x; obs_ready_after = 1'b0; obs_unstable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs_addr[i] = 'x; obs_wdata[i] = 'x; obs_be[i] = 'x; obs_we[i] = 'x;
    end
    @(negedge clk);
    obs_ready_acc = req_ready;
    req_valid = 1'b1; req_write = w; req_addr = addr; req_size = size;
    req_zext = zext; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; wcnt = 0; done = 0; in_tx = 0;
    while (!done && cyc < 300) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        obs_resp_cyc = cyc; obs_rdata = resp_rdata; obs_err = resp_err;
        done = 1;
      end else begin
        if (mem_req) begin
          obs_req_cycles++;
          if (obs_first_req_cyc < 0) obs_first_req_cyc = cyc;
          if (!in_tx) begin
            in_tx = 1; wcnt = 0; obs_ntx++;
            if (obs_ntx <= 2) begin
              obs_addr[obs_ntx-1] = mem_addr; obs_be[obs_ntx-1] = mem_be;
              obs_wdata[obs_ntx-1] = mem_wdata; obs_we[obs_ntx-1] = mem_we;
            end
          end else if (obs_ntx <= 2 && (mem_addr !== obs_addr[obs_ntx-1] ||
                       mem_be !== obs_be[obs_ntx-1] || mem_we !== obs_we[obs_ntx-1] ||
                       mem_wdata !== obs_wdata[obs_ntx-1])) begin
            obs_unstable = 1'b1;
          end
          if (!no_ack && wcnt == waits) begin
            mem_ack = 1'b1;
            mem_rdata = (obs_ntx == 1) ? rdw0 : rdw1;
            in_tx = 0;
          end else begin
            wcnt++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (done) begin
      @(negedge clk);
      obs_ready_after = req_ready && !resp_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nchecks++; if (req_ready !== 1'b1) begin nerrors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    nchecks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      nerrors++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected 0/0/0", resp_valid, resp_err, resp_rdata); end
    nchecks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      nerrors++; $display("FAIL reset_mem: got req=%b we=%b a=%h be=%h d=%h expected all 0", mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    // signed byte load from offset 3
    run_access(1'b0, 32'h103, 2'b10, 1'b0, 32'h0, 0, 1'b0, 32'h1122_33F0, 32'h0);
    nchecks++; if (obs_addr[0] !== 32'h100 || obs_be[0] !== 4'hF || obs_we[0] !== 1'b0) begin
      nerrors++; $display("FAIL lb_bus: got a=%h be=%h we=%b expected 100/f/0", obs_addr[0], obs_be[0], obs_we[0]); end
    nchecks++; if (obs_rdata !== 32'hFFFF_FFF0 || obs_err !== 1'b0 || obs_resp_cyc != 2) begin
      nerrors++; $display("FAIL lb_resp: got d=%h e=%b cyc=%0d expected fffffff0/0/2", obs_rdata, obs_err, obs_resp_cyc); end
    // halfword store at offset 2
    run_access(1'b1, 32'h202, 2'b01, 1'b0, 32'h0000_BEEF, 0, 1'b0, 32'h0, 32'h0);
    nchecks++; if (obs_addr[0] !== 32'h200 || obs_be[0] !== 4'b0011 || obs_we[0] !== 1'b1 || obs_wdata[0][15:0] !== 16'hBEEF) begin
      nerrors++; $display("FAIL sh_bus: got a=%h be=%b we=%b d=%h expected 200/0011/1/beef", obs_addr[0], obs_be[0], obs_we[0], obs_wdata[0]); end
    nchecks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0 || obs_resp_cyc != 2) begin
      nerrors++; $display("FAIL sh_resp: got e=%b d=%h cyc=%0d expected 0/0/2", obs_err, obs_rdata, obs_resp_cyc); end
    // misaligned word load
    run_access(1'b0, 32'h101, 2'b00, 1'b0, 32'h0, 0, 1'b0, 32'hAABB_CCDD, 32'hEEFF_0011);
`ifdef MISALIGN_SPLIT_EN
    nchecks++; if (obs_ntx != 2 || obs_addr[0] !== 32'h100 || obs_addr[1] !== 32'h104) begin
      nerrors++; $display("FAIL lw_split_bus: got n=%0d a0=%h a1=%h expected 2/100/104", obs_ntx, obs_addr[0], obs_addr[1]); end
    nchecks++; if (obs_rdata !== 32'hBBCC_DDEE || obs_err !== 1'b0 || obs_resp_cyc != 3) begin
      nerrors++; $display("FAIL lw_split_resp: got d=%h e=%b cyc=%0d expected bbccddee/0/3", obs_rdata, obs_err, obs_resp_cyc); end
`else
    nchecks++; if (obs_ntx != 0 || obs_first_req_cyc != -1) begin
      nerrors++; $display("FAIL lw_misalign_bus: got n=%0d first=%0d expected no mem_req", obs_ntx, obs_first_req_cyc); end
    nchecks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_resp_cyc != 1) begin
      nerrors++; $display("FAIL lw_misalign_resp: got e=%b d=%h cyc=%0d expected 1/0/1", obs_err, obs_rdata, obs_resp_cyc); end
`endif
    // illegal size
    run_access(1'b0, 32'h400, 2'b11, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, 32'h0);
    nchecks++; if (obs_ntx != 0 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_resp_cyc != 1) begin
      nerrors++; $display("FAIL size11: got n=%0d e=%b d=%h cyc=%0d expected 0/1/0/1", obs_ntx, obs_err, obs_rdata, obs_resp_cyc); end
  endtask

  task automatic test_random();
    logic        w, zext;
    logic [31:0] addr, wdata, r0, r1;
    logic [1:0]  size;
    int          waits, exp_cyc;
    for (int it = 0; it < 80; it++) begin
      w = 1'($urandom_range(0, 1)); zext = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom; r0 = $urandom; r1 = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      waits = $urandom_range(0, 3);
      model(w, addr, size, zext, wdata, r0, r1);
      run_access(w, addr, size, zext, wdata, waits, 1'b0, r0, r1);
      exp_cyc = exp_err ? 1 : 1 + exp_ntx * (waits + 1);
      nchecks++; if (obs_ready_acc !== 1'b1 || obs_ready_after !== 1'b1) begin
        nerrors++; $display("FAIL rnd%0d_ready: got acc=%b after=%b expected 1/1", it, obs_ready_acc, obs_ready_after); end
      nchecks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin
        nerrors++; $display("FAIL rnd%0d_resp a=%h sz=%0d w=%b: got e=%b d=%h expected e=%b d=%h", it, addr, size, w, obs_err, obs_rdata, exp_err, exp_rdata); end
      nchecks++; if (obs_ntx != exp_ntx || obs_resp_cyc != exp_cyc || obs_unstable !== 1'b0) begin
        nerrors++; $display("FAIL rnd%0d_timing: got n=%0d cyc=%0d unstable=%b expected n=%0d cyc=%0d 0", it, obs_ntx, obs_resp_cyc, obs_unstable, exp_ntx, exp_cyc); end
      for (int t = 0; t < exp_ntx; t++) begin
        nchecks++;
        if (obs_addr[t] !== exp_addr[t] || obs_be[t] !== exp_be[t] || obs_we[t] !== w ||
            (w && ((obs_wdata[t] & {{8{exp_be[t][3]}}, {8{exp_be[t][2]}}, {8{exp_be[t][1]}}, {8{exp_be[t][0]}}}) !== exp_wdata[t]))) begin
          nerrors++;
          $display("FAIL rnd%0d_tx%0d: got a=%h be=%h we=%b d=%h expected a=%h be=%h we=%b d=%h", it, t,
                   obs_addr[t], obs_be[t], obs_we[t], obs_wdata[t], exp_addr[t], exp_be[t], w, exp_wdata[t]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    // ack on the last allowed cycle still completes normally
    run_access(1'b0, 32'h500, 2'b00, 1'b0, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 32'h0);
    nchecks++; if (obs_err !== 1'b0 || obs_rdata !== 32'hCAFE_F00D || obs_resp_cyc != TIMEOUT + 1) begin
      nerrors++; $display("FAIL ack_at_expiry: got e=%b d=%h cyc=%0d expected 0/cafef00d/%0d", obs_err, obs_rdata, obs_resp_cyc, TIMEOUT + 1); end
    // no ack at all
    run_access(1'b0, 32'h600, 2'b00, 1'b0, 32'h0, 0, 1'b1, 32'h0, 32'h0);
    nchecks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_req_cycles != TIMEOUT || obs_resp_cyc != TIMEOUT + 1) begin
      nerrors++; $display("FAIL timeout: got e=%b d=%h reqcyc=%0d cyc=%0d expected 1/0/%0d/%0d", obs_err, obs_rdata, obs_req_cycles, obs_resp_cyc, TIMEOUT, TIMEOUT + 1); end
    nchecks++; if (obs_ready_after !== 1'b1) begin
      nerrors++; $display("FAIL timeout_ready: got %b expected 1", obs_ready_after); end
    run_access(1'b0, 32'h604, 2'b01, 1'b1, 32'h0, 1, 1'b0, 32'h8001_0000, 32'h0);
    nchecks++; if (obs_ready_acc !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'h0000_8001) begin
      nerrors++; $display("FAIL after_timeout: got rdy=%b e=%b d=%h expected 1/0/00008001", obs_ready_acc, obs_err, obs_rdata); end
  endtask

  task automatic test_reset_mid();
    int seen_resp = 0, seen_req = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_size = 2'b00; req_zext = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    nchecks++; if (mem_req !== 1'b1) begin nerrors++; $display("FAIL mid_acc1: got mem_req=%b expected 1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchecks++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      nerrors++; $display("FAIL mid_reset: got rdy=%b req=%b resp=%b expected 1/0/0", req_ready, mem_req, resp_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
      if (mem_req) seen_req++;
    end
    mem_ack = 1'b0;
    nchecks++; if (seen_resp != 0 || seen_req != 0) begin
      nerrors++; $display("FAIL late_ack: got resp=%0d req=%0d expected 0/0", seen_resp, seen_req); end
    run_access(1'b0, 32'h300, 2'b10, 1'b1, 32'h0, 0, 1'b0, 32'h9A00_0000, 32'h0);
    nchecks++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0000_009A || obs_resp_cyc != 2) begin
      nerrors++; $display("FAIL after_mid_reset: got e=%b d=%h cyc=%0d expected 0/0000009a/2", obs_err, obs_rdata, obs_resp_cyc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
